// File: rtl/fractal_pkg.sv
// fractal_pkg: shared encodings for the fractal pixel engine.
//   lane_state_e : per-lane FREE / ITER / DONE
//   fsm_state_e  : top-level IDLE / RUN
//   TAG_*        : bit positions of the per-pixel tag carried by each lane
//   escape_limit : 4.0 in fixed point for a given number of fractional bits
package fractal_pkg;

  typedef enum logic [1:0] {
    LANE_FREE = 2'd0,
    LANE_ITER = 2'd1,
    LANE_DONE = 2'd2
  } lane_state_e;

  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_RUN  = 1'b1
  } fsm_state_e;

  localparam int TAG_W    = 3;
  localparam int TAG_USER = 0;  // pixel (0,0)
  localparam int TAG_LAST = 1;  // last pixel of a line
  localparam int TAG_EOF  = 2;  // last pixel of the frame

  function automatic logic [63:0] escape_limit(input int frac_bits);
    return 64'd4 << frac_bits;
  endfunction

endpackage

// File: rtl/fractal_pixel_engine_if.sv
// fractal_pixel_engine_if: AXI-Stream style output of the pixel engine.
//   tdata  : iteration count of the pixel
//   tvalid : beat available      tready : sink accepts
//   tlast  : last pixel of line  tuser  : start of frame
// master modport drives the stream, slave modport consumes it.
interface fractal_pixel_engine_if #(
  parameter int ITER_W = 8
);
  logic [ITER_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/fractal_lane.sv
// fractal_lane: one escape-time iteration lane.
//   clk_i/rst_ni : clock, synchronous active-low reset
//   dispatch_i   : load a new pixel (honoured only while FREE)
//   zr0_i/zi0_i  : initial z;  kre_i/kim_i : additive constant
//   tag_i        : pixel tag {eof, last, user}
//   max_iter_i   : iteration limit
//   ack_i        : result handshaken (honoured only while DONE)
//   state_o/count_o/tag_o : lane state, update count, pixel tag
module fractal_lane
  import fractal_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 8,
  parameter int ITER_W    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     dispatch_i,
  input  logic signed [DATA_W-1:0] zr0_i,
  input  logic signed [DATA_W-1:0] zi0_i,
  input  logic signed [DATA_W-1:0] kre_i,
  input  logic signed [DATA_W-1:0] kim_i,
  input  logic [TAG_W-1:0]         tag_i,
  input  logic [ITER_W-1:0]        max_iter_i,
  input  logic                     ack_i,
  output lane_state_e              state_o,
  output logic [ITER_W-1:0]        count_o,
  output logic [TAG_W-1:0]         tag_o
);

  localparam int PW = 2 * DATA_W;
  localparam logic [63:0] LIMIT_64 = escape_limit(FRAC_BITS);
  localparam logic signed [DATA_W+1:0] ESC_LIMIT = LIMIT_64[DATA_W+1:0];

  lane_state_e              state_q;
  logic signed [DATA_W-1:0] zr_q, zi_q, kre_q, kim_q;
  logic [ITER_W-1:0]        count_q;
  logic [TAG_W-1:0]         tag_q;

  logic signed [PW-1:0]     zr_ext_s, zi_ext_s, p_rr_s, p_ii_s, p_ri_s;
  logic signed [DATA_W-1:0] zr2_s, zi2_s, zri2_s, zr_d, zi_d;
  logic signed [DATA_W+1:0] mag_s;
  logic                     escape_s, stop_s;

  // Iteration datapath: full-width products, arithmetic rescale, wrap to DATA_W.
  always_comb begin
    zr_ext_s = {{DATA_W{zr_q[DATA_W-1]}}, zr_q};
    zi_ext_s = {{DATA_W{zi_q[DATA_W-1]}}, zi_q};
    p_rr_s   = zr_ext_s * zr_ext_s;
    p_ii_s   = zi_ext_s * zi_ext_s;
    p_ri_s   = (zr_ext_s * zi_ext_s) <<< 1;
    zr2_s    = DATA_W'(p_rr_s >>> FRAC_BITS);
    zi2_s    = DATA_W'(p_ii_s >>> FRAC_BITS);
    zri2_s   = DATA_W'(p_ri_s >>> FRAC_BITS);
    // Two guard bits keep the magnitude sum from wrapping before the compare.
    mag_s    = {{2{zr2_s[DATA_W-1]}}, zr2_s} + {{2{zi2_s[DATA_W-1]}}, zi2_s};
    escape_s = (mag_s > ESC_LIMIT);
    zr_d     = zr2_s - zi2_s + kre_q;
    zi_d     = zri2_s + kim_q;
    stop_s   = escape_s || (count_q == max_iter_i);
  end

  // Lane state machine: load on dispatch, iterate until stop, hold until acked.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= LANE_FREE;
      zr_q    <= '0;
      zi_q    <= '0;
      kre_q   <= '0;
      kim_q   <= '0;
      count_q <= '0;
      tag_q   <= '0;
    end else begin
      case (state_q)
        LANE_FREE: begin
          if (dispatch_i) begin
            zr_q    <= zr0_i;
            zi_q    <= zi0_i;
            kre_q   <= kre_i;
            kim_q   <= kim_i;
            tag_q   <= tag_i;
            count_q <= '0;
            state_q <= LANE_ITER;
          end
        end
        LANE_ITER: begin
          if (stop_s) begin
            state_q <= LANE_DONE;
          end else begin
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            count_q <= count_q + ITER_W'(1);
          end
        end
        LANE_DONE: begin
          if (ack_i) begin
            state_q <= LANE_FREE;
          end
        end
        default: state_q <= LANE_FREE;
      endcase
    end
  end

  assign state_o = state_q;
  assign count_o = count_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/fractal_pixel_engine.sv
// fractal_pixel_engine: raster-order Mandelbrot/Julia escape-time generator
// with LANES parallel iteration lanes and in-order AXI-Stream output.
//   out_stream_aclk / periph_resetn : clock, synchronous active-low reset
//   start, mode, origin_re/im, step, julia_re/im, max_iter : frame config,
//     latched when start is accepted in IDLE
//   busy       : frame in progress
//   out_stream : iteration counts (tdata), tlast = end of line, tuser = (0,0)
// Optional feature: define FRACTAL_JULIA_EN to build Julia mode (mode = 1);
// without it the engine is Mandelbrot only and mode/julia_* are ignored.
module fractal_pixel_engine
  import fractal_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 8,
  parameter int X_SIZE    = 640,
  parameter int Y_SIZE    = 480,
  parameter int ITER_W    = 8
) (
  input  logic                     out_stream_aclk,
  input  logic                     periph_resetn,
  input  logic                     start,
  input  logic                     mode,
  input  logic signed [DATA_W-1:0] origin_re,
  input  logic signed [DATA_W-1:0] origin_im,
  input  logic signed [DATA_W-1:0] step,
  input  logic signed [DATA_W-1:0] julia_re,
  input  logic signed [DATA_W-1:0] julia_im,
  input  logic [ITER_W-1:0]        max_iter,
  output logic                     busy,
  fractal_pixel_engine_if.master   out_stream
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(Y_SIZE - 1);

  fsm_state_e               state_q;
  logic                     busy_q, issued_q;
  logic [LW-1:0]            d_q, o_q;
  logic [XW-1:0]            x_q;
  logic [YW-1:0]            y_q;
  logic signed [DATA_W-1:0] cre_q, cim_q, row_re_q, step_q;
  logic [ITER_W-1:0]        max_iter_q;
`ifdef FRACTAL_JULIA_EN
  logic                     mode_q;
  logic signed [DATA_W-1:0] jre_q, jim_q;
`else
  logic                     unused_s;
  assign unused_s = ^{mode, julia_re, julia_im};
`endif

  lane_state_e              lane_state_s [LANES];
  logic [ITER_W-1:0]        lane_count_s [LANES];
  logic [TAG_W-1:0]         lane_tag_s   [LANES];
  logic [LANES-1:0]         dispatch_s, ack_s;
  logic signed [DATA_W-1:0] zr0_s, zi0_s, kre_s, kim_s;
  logic [TAG_W-1:0]         tag_s;
  logic                     issue_s, hs_s, tvalid_s;

  // Seed and tag for the pixel currently at the dispatcher.
  always_comb begin
    tag_s           = '0;
    tag_s[TAG_USER] = (x_q == '0) && (y_q == '0);
    tag_s[TAG_LAST] = (x_q == X_LAST);
    tag_s[TAG_EOF]  = (x_q == X_LAST) && (y_q == Y_LAST);
    zr0_s = '0;
    zi0_s = '0;
    kre_s = cre_q;
    kim_s = cim_q;
`ifdef FRACTAL_JULIA_EN
    if (mode_q) begin
      zr0_s = cre_q;
      zi0_s = cim_q;
      kre_s = jre_q;
      kim_s = jim_q;
    end else begin
      zr0_s = '0;
      zi0_s = '0;
    end
`endif
  end

  // Dispatch to lane d when it is free; collect from lane o when it is done.
  always_comb begin
    tvalid_s = (lane_state_s[o_q] == LANE_DONE);
    hs_s     = tvalid_s && out_stream.tready;
    issue_s  = (state_q == FSM_RUN) && !issued_q && (lane_state_s[d_q] == LANE_FREE);
    for (int i = 0; i < LANES; i++) begin
      dispatch_s[i] = issue_s && (d_q == LW'(i));
      ack_s[i]      = hs_s && (o_q == LW'(i));
    end
  end

  assign out_stream.tvalid = tvalid_s;
  assign out_stream.tdata  = lane_count_s[o_q];
  assign out_stream.tlast  = lane_tag_s[o_q][TAG_LAST];
  assign out_stream.tuser  = lane_tag_s[o_q][TAG_USER];
  assign busy              = busy_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fractal_lane #(
      .DATA_W    (DATA_W),
      .FRAC_BITS (FRAC_BITS),
      .ITER_W    (ITER_W)
    ) u_lane (
      .clk_i      (out_stream_aclk),
      .rst_ni     (periph_resetn),
      .dispatch_i (dispatch_s[g]),
      .zr0_i      (zr0_s),
      .zi0_i      (zi0_s),
      .kre_i      (kre_s),
      .kim_i      (kim_s),
      .tag_i      (tag_s),
      .max_iter_i (max_iter_q),
      .ack_i      (ack_s[g]),
      .state_o    (lane_state_s[g]),
      .count_o    (lane_count_s[g]),
      .tag_o      (lane_tag_s[g])
    );
  end

  // Top FSM with raster walker; c advances by adding step, never multiplying.
  always_ff @(posedge out_stream_aclk) begin
    if (!periph_resetn) begin
      state_q    <= FSM_IDLE;
      busy_q     <= 1'b0;
      issued_q   <= 1'b0;
      d_q        <= '0;
      o_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      cre_q      <= '0;
      cim_q      <= '0;
      row_re_q   <= '0;
      step_q     <= '0;
      max_iter_q <= '0;
`ifdef FRACTAL_JULIA_EN
      mode_q     <= 1'b0;
      jre_q      <= '0;
      jim_q      <= '0;
`endif
    end else begin
      case (state_q)
        FSM_IDLE: begin
          if (start) begin
            state_q    <= FSM_RUN;
            busy_q     <= 1'b1;
            issued_q   <= 1'b0;
            d_q        <= '0;
            o_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            cre_q      <= origin_re;
            cim_q      <= origin_im;
            row_re_q   <= origin_re;
            step_q     <= step;
            max_iter_q <= max_iter;
`ifdef FRACTAL_JULIA_EN
            mode_q     <= mode;
            jre_q      <= julia_re;
            jim_q      <= julia_im;
`endif
          end
        end
        FSM_RUN: begin
          if (issue_s) begin
            d_q <= (d_q == LAST_LANE) ? '0 : d_q + LW'(1);
            if (x_q == X_LAST) begin
              x_q   <= '0;
              cre_q <= row_re_q;
              cim_q <= cim_q + step_q;
              if (y_q == Y_LAST) begin
                issued_q <= 1'b1;
              end else begin
                y_q <= y_q + YW'(1);
              end
            end else begin
              x_q   <= x_q + XW'(1);
              cre_q <= cre_q + step_q;
            end
          end
          if (hs_s) begin
            o_q <= (o_q == LAST_LANE) ? '0 : o_q + LW'(1);
            if (lane_tag_s[o_q][TAG_EOF]) begin
              state_q <= FSM_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= FSM_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
